// File: rtl/limp_sram_responder.sv
// LIMP-attached SRAM: one request at a time, response WAIT_CYCLES+1 cycles after acceptance.
// No backpressure; driving cmd to NOP while a request waits aborts it without a response.
module limp_sram_responder #(
  parameter logic [33:0] BASE_ADDR   = 34'h0_8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [69:0] i_limp_req,
  output logic [33:0] o_limp_rsp
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [34:0] SPAN = 35'(DEPTH_WORDS) << 2;

  localparam logic [1:0] CMD_NOP          = 2'd0;
  localparam logic [1:0] CMD_READ         = 2'd1;
  localparam logic [1:0] CMD_WRITE        = 2'd2;
  localparam logic [1:0] CMD_AMO_READ     = 2'd3;
  localparam logic [1:0] SZ_BYTE          = 2'd0;
  localparam logic [1:0] SZ_HALF          = 2'd1;
  localparam logic [1:0] SZ_WORD          = 2'd2;
  localparam logic [1:0] ST_NOT_READY     = 2'd0;
  localparam logic [1:0] ST_READY_READ    = 2'd1;
  localparam logic [1:0] ST_READY_WRITE   = 2'd2;
  localparam logic [1:0] ST_READY_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [69:0] r_req;
  logic [33:0] r_rsp;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [69:0]   w_src;
  logic [1:0]    w_cmd;
  logic [33:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [1:0]    w_size;
  logic [34:0]   w_off;
  logic [AW-1:0] w_idx;
  logic          w_illegal;
  logic [31:0]   w_word;
  logic [31:0]   w_rdata;
  logic [31:0]   w_wword;
  logic [33:0]   w_rsp_nxt;
  logic          w_we;

  // Live request while idle (acceptance decision), latched copy afterwards.
  assign w_src   = (r_state == S_IDLE) ? i_limp_req : r_req;
  assign w_cmd   = w_src[69:68];
  assign w_addr  = w_src[67:34];
  assign w_wdata = w_src[33:2];
  assign w_size  = w_src[1:0];

  // 35-bit subtract: bit 34 set means the address lies below the window.
  assign w_off  = {1'b0, w_addr} - {1'b0, BASE_ADDR};
  assign w_idx  = w_off[AW+1:2];
  assign w_word = r_mem[w_idx];

  always_comb begin
    w_illegal = 1'b0;
    if (w_off[34] || (w_off >= SPAN))                      w_illegal = 1'b1;
    if (w_size == 2'b11)                                   w_illegal = 1'b1;
    if ((w_size == SZ_HALF) && w_addr[0])                  w_illegal = 1'b1;
    if ((w_size == SZ_WORD) && (w_addr[1:0] != 2'b00))     w_illegal = 1'b1;
    if ((w_cmd == CMD_AMO_READ) && (w_size != SZ_WORD))    w_illegal = 1'b1;
  end

  always_comb begin
    w_rdata = w_word;
    w_wword = w_word;
    case (w_size)
      SZ_BYTE: begin
        case (w_addr[1:0])
          2'd0:    begin w_rdata = {24'h0, w_word[7:0]};   w_wword[7:0]   = w_wdata[7:0]; end
          2'd1:    begin w_rdata = {24'h0, w_word[15:8]};  w_wword[15:8]  = w_wdata[7:0]; end
          2'd2:    begin w_rdata = {24'h0, w_word[23:16]}; w_wword[23:16] = w_wdata[7:0]; end
          default: begin w_rdata = {24'h0, w_word[31:24]}; w_wword[31:24] = w_wdata[7:0]; end
        endcase
      end
      SZ_HALF: begin
        if (w_addr[1]) begin
          w_rdata = {16'h0, w_word[31:16]};
          w_wword[31:16] = w_wdata[15:0];
        end else begin
          w_rdata = {16'h0, w_word[15:0]};
          w_wword[15:0] = w_wdata[15:0];
        end
      end
      default: w_wword = w_wdata;
    endcase
  end

  always_comb begin
    if (w_illegal)                w_rsp_nxt = {ST_READY_ILLEGAL, 32'h0};
    else if (w_cmd == CMD_WRITE)  w_rsp_nxt = {ST_READY_WRITE, 32'h0};
    else                          w_rsp_nxt = {ST_READY_READ, w_rdata};
  end

  // Writes land on the edge that ends RESPOND; reset forces IDLE so a pending write is dropped.
  assign w_we = (r_state == S_RESPOND) && (w_cmd == CMD_WRITE) && !w_illegal;

  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_idx] <= w_wword;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_req   <= '0;
      r_rsp   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rsp <= '0;
          if ((w_cmd == CMD_READ) || (w_cmd == CMD_WRITE) || (w_cmd == CMD_AMO_READ)) begin
            r_req <= i_limp_req;
            r_cnt <= 4'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              r_state <= S_RESPOND;
              r_rsp   <= w_rsp_nxt;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (i_limp_req[69:68] == CMD_NOP) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else if (r_cnt == 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= S_RESPOND;
            r_rsp   <= w_rsp_nxt;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESPOND: begin
          r_state <= S_IDLE;
          r_rsp   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_rsp   <= '0;
        end
      endcase
    end
  end

  assign o_limp_rsp = r_rsp;

endmodule

// File: tb/tb_limp_sram_responder.sv
// Bench for limp_sram_responder: one instance with WAIT_CYCLES=0, one with WAIT_CYCLES=3.
module tb_limp_sram_responder;

  localparam logic [1:0] CMD_NOP = 2'd0, CMD_RD = 2'd1, CMD_WR = 2'd2, CMD_AMO = 2'd3;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;
  localparam logic [1:0] ST_NR = 2'd0, ST_RD = 2'd1, ST_WR = 2'd2, ST_ILL = 2'd3;
  localparam logic [33:0] BASE = 34'h0_8000_0000;

  typedef struct packed {
    logic [1:0]  st;
    logic [31:0] rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst0_n, rst3_n;
  logic [69:0] req0, req3;
  logic [33:0] rsp0, rsp3;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  logic [31:0] m0 [1024];
  logic [31:0] m3 [1024];

  always #5 clk = ~clk;

  limp_sram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst0_n), .i_limp_req(req0), .o_limp_rsp(rsp0));
  limp_sram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst3_n), .i_limp_req(req3), .o_limp_rsp(rsp3));

  task automatic check_eq(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [69:0] mk(input logic [1:0] cmd, input logic [33:0] a,
                                     input logic [31:0] wd, input logic [1:0] sz);
    return {cmd, a, wd, sz};
  endfunction

  function automatic logic [33:0] get_rsp(input bit sel);
    return sel ? rsp3 : rsp0;
  endfunction

  task automatic drive(input bit sel, input logic [69:0] r);
    if (sel) req3 = r;
    else     req0 = r;
  endtask

  // Reference model: legality, lane extraction and memory update straight from the block's rules.
  task automatic predict(input bit sel, input logic [69:0] r, output exp_t e);
    logic [1:0]  cmd, sz;
    logic [33:0] a, off;
    logic [31:0] wd, w;
    logic [9:0]  idx;
    bit          ill;
    int          sh;
    cmd = r[69:68]; a = r[67:34]; wd = r[33:2]; sz = r[1:0];
    ill = (a < BASE) || (a >= BASE + 34'd4096) || (sz == 2'b11) ||
          (sz == SZ_H && a[0]) || (sz == SZ_W && a[1:0] != 2'b00) ||
          (cmd == CMD_AMO && sz != SZ_W);
    off = a - BASE;
    idx = off[11:2];
    w   = sel ? m3[idx] : m0[idx];
    sh  = 8 * int'(a[1:0]);
    e.st = ST_ILL;
    e.rd = 32'h0;
    if (!ill && cmd == CMD_WR) begin
      e.st = ST_WR;
      case (sz)
        SZ_B:    w[sh +: 8] = wd[7:0];
        SZ_H:    if (a[1]) w[31:16] = wd[15:0]; else w[15:0] = wd[15:0];
        default: w = wd;
      endcase
      if (sel) m3[idx] = w;
      else     m0[idx] = w;
    end else if (!ill) begin
      e.st = ST_RD;
      case (sz)
        SZ_B:    e.rd = (w >> sh) & 32'hff;
        SZ_H:    e.rd = a[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
        default: e.rd = w;
      endcase
    end
  endtask

  // Present a request in an idle cycle, leave it held, and check latency and response.
  task automatic txn(input bit sel, input string tag, input logic [1:0] cmd,
                     input logic [33:0] a, input logic [31:0] wd, input logic [1:0] sz);
    logic [69:0] r;
    logic [33:0] o;
    exp_t        e;
    int          lat, w;
    bit          got;
    w = sel ? 3 : 0;
    r = mk(cmd, a, wd, sz);
    @(posedge clk); #1;
    drive(sel, r);
    predict(sel, r, e);
    exp_q.push_back(e);
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      o = get_rsp(sel);
      if (k == 0) check_eq({tag, "_idle"}, o, 34'h0);
      if (o[33:32] != ST_NR) begin
        got = 1'b1;
        lat = k;
      end
    end
    check_eq({tag, "_lat"}, 34'(lat), 34'(w + 1));
    e = exp_q.pop_front();
    if (got) check_eq({tag, "_rsp"}, o, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [69:0] r;
    exp_t        e;
    bit          got;

    rst0_n = 1'b0; rst3_n = 1'b0; req0 = '0; req3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rsp0", rsp0, 34'h0);
    check_eq("rst_rsp3", rsp3, 34'h0);
    rst0_n = 1'b1; rst3_n = 1'b1;

    // Write then read presented in the write's response cycle.
    @(posedge clk); #1;
    r = mk(CMD_WR, BASE + 34'h10, 32'hDEADBEEF, SZ_W);
    drive(0, r); predict(0, r, e); exp_q.push_back(e);
    @(negedge clk); check_eq("b2b_idle", rsp0, 34'h0);
    @(posedge clk); #1;
    r = mk(CMD_RD, BASE + 34'h10, 32'h0, SZ_W);
    drive(0, r); predict(0, r, e); exp_q.push_back(e);
    @(negedge clk); e = exp_q.pop_front(); check_eq("b2b_wr", rsp0, e);
    @(negedge clk); check_eq("b2b_gap", rsp0, 34'h0);
    @(posedge clk); #1; drive(0, '0);
    @(negedge clk); e = exp_q.pop_front(); check_eq("b2b_rd", rsp0, e);

    txn(0, "wr_b13", CMD_WR,  BASE + 34'h13, 32'h000000AA, SZ_B);
    txn(0, "rd_w10", CMD_RD,  BASE + 34'h10, 32'h0, SZ_W);
    txn(0, "rd_h12", CMD_RD,  BASE + 34'h12, 32'h0, SZ_H);
    txn(0, "rd_h10", CMD_RD,  BASE + 34'h10, 32'h0, SZ_H);
    txn(0, "rd_b11", CMD_RD,  BASE + 34'h11, 32'h0, SZ_B);
    txn(0, "wr_h10", CMD_WR,  BASE + 34'h10, 32'h12345678, SZ_H);
    txn(0, "amo_w",  CMD_AMO, BASE + 34'h10, 32'h0, SZ_W);
    txn(0, "il_rdw", CMD_RD,  BASE + 34'h11, 32'h0, SZ_W);
    txn(0, "il_end", CMD_RD,  BASE + 34'h1000, 32'h0, SZ_W);
    txn(0, "il_amo", CMD_AMO, BASE + 34'h10, 32'h0, SZ_B);
    txn(0, "il_sz3", CMD_WR,  BASE + 34'h10, 32'hFFFFFFFF, 2'b11);
    txn(0, "il_h11", CMD_WR,  BASE + 34'h11, 32'hFFFFFFFF, SZ_H);
    txn(0, "il_low", CMD_WR,  BASE - 34'h4, 32'hFFFFFFFF, SZ_W);
    txn(0, "il_chk", CMD_RD,  BASE + 34'h10, 32'h0, SZ_W);
    txn(0, "wr_top", CMD_WR,  BASE + 34'hFFC, 32'h55AA33CC, SZ_W);
    txn(0, "rd_top", CMD_RD,  BASE + 34'hFFC, 32'h0, SZ_W);
    @(posedge clk); #1; drive(0, '0);

    txn(1, "w3_wr", CMD_WR, BASE + 34'h20, 32'h12345678, SZ_W);
    txn(1, "w3_rd", CMD_RD, BASE + 34'h20, 32'h0, SZ_W);
    txn(1, "w3_rb", CMD_RD, BASE + 34'h23, 32'h0, SZ_B);

    // Abort: NOP in the second wait cycle of a write.
    @(posedge clk); #1; drive(1, mk(CMD_WR, BASE + 34'h20, 32'hCAFEF00D, SZ_W));
    @(posedge clk); #1;
    @(posedge clk); #1; drive(1, '0);
    repeat (6) begin
      @(negedge clk); check_eq("abort_quiet", rsp3, 34'h0);
    end
    txn(1, "abort_rd", CMD_RD, BASE + 34'h20, 32'h0, SZ_W);

    // Reset pulse during the wait phase of a write.
    @(posedge clk); #1; drive(1, mk(CMD_WR, BASE + 34'h20, 32'hBAD0BAD0, SZ_W));
    @(posedge clk); #2; rst3_n = 1'b0;
    #1; check_eq("rstw_rsp", rsp3, 34'h0);
    @(posedge clk); #1; rst3_n = 1'b1; drive(1, '0);
    txn(1, "rstw_rd", CMD_RD, BASE + 34'h20, 32'h0, SZ_W);

    // Reset asserted during the response cycle of a write: the write must be dropped.
    @(posedge clk); #1; drive(1, mk(CMD_WR, BASE + 34'h20, 32'h0BADF00D, SZ_W));
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (rsp3[33:32] != ST_NR) got = 1'b1;
    end
    check_eq("rstr_pre", rsp3, {ST_WR, 32'h0});
    #1; rst3_n = 1'b0;
    #1; check_eq("rstr_rsp", rsp3, 34'h0);
    @(posedge clk); #1; rst3_n = 1'b1; drive(1, '0);
    txn(1, "rstr_rd", CMD_RD, BASE + 34'h20, 32'h0, SZ_W);
    @(posedge clk); #1; drive(1, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/limp_sram_responder.md
LIMP_SRAM_RESPONDER -- requirements
Module: limp_sram_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 34'h0_8000_0000, meaning the physical byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words stored (power of two, >=2).
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, meaning the extra cycles inserted before each response (0..15).
REQ-004 Clocking and reset SHALL be exactly: one clock; reset is asynchronous and active-low.
REQ-005 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_limp_req  input  70  LIMP request: cmd[69:68], addr[67:34] (34-bit paddr), wdata[33:2], size[1:0].
REQ-008 o_limp_rsp  output  34  LIMP response: status[33:32], rdata[31:0]; driven from flops only.

Function
REQ-009 SHALL be a LIMP responder with FSM states IDLE, WAIT, RESPOND.
REQ-010 IDLE: when cmd is READ, WRITE or AMO_READ, latch the request, load the wait counter with WAIT_CYCLES, and enter WAIT (WAIT_CYCLES>0) or RESPOND (WAIT_CYCLES=0).
REQ-011 WAIT: decrement counter each cycle; enter RESPOND when the counter reaches 0.
REQ-012 Request first seen in cycle N SHALL produce a non-NOT_READY status in exactly cycle N+1+WAIT_CYCLES.
REQ-013 RESPOND: status SHALL be non-NOT_READY for exactly one cycle, then return to IDLE; the completing edge is the end of that cycle.
REQ-014 In the cycle after RESPOND, status SHALL be NOT_READY, even if a new request is already present; that request is accepted in this IDLE cycle.
REQ-015 Abort: if cmd is NOP in any WAIT cycle, or in the cycle before RESPOND, return to IDLE with no response and no memory write.
REQ-016 Changes to addr, wdata or size after acceptance SHALL be ignored; the latched copy is used.
REQ-017 Illegal request, decided at acceptance:
- addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS);
- halfword with addr[0]=1;
- word with addr[1:0]!=0;
- size encoding 2'b11;
- AMO_READ with size other than WORD.
REQ-018 An illegal request SHALL respond LIMP_READY_ILLEGAL with rdata 0 and SHALL not modify memory.
REQ-019 A legal READ or AMO_READ SHALL respond LIMP_READY_READ, with rdata right-justified and zero-extended:
- byte lane addr[1:0] to [7:0];
- halfword lane addr[1] to [15:0];
- word to [31:0].
REQ-020 A legal WRITE SHALL respond LIMP_READY_WRITE with rdata 0.
REQ-021 A legal WRITE SHALL update memory at the completing edge only: byte from wdata[7:0], halfword from wdata[15:0], word from wdata[31:0]; other lanes unchanged.
REQ-022 Word index SHALL be (addr-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits after the range check.
REQ-023 Read data SHALL reflect all writes completed on earlier edges (no stale data on back-to-back write then read).
REQ-024 Outside RESPOND, status SHALL be LIMP_NOT_READY and rdata SHALL be 0.

Reset
REQ-025 Asserting i_rst_n low SHALL immediately force: FSM to IDLE, counter to 0, status to LIMP_NOT_READY, rdata to 0.
REQ-026 Reset mid-transaction SHALL discard the latched request; a pending write SHALL not occur.
REQ-027 Memory contents SHALL not be reset.
REQ-028 After reset release, the first request is accepted on the first rising edge with i_rst_n high.

Verification
REQ-029 WAIT_CYCLES=0: WRITE word 0xDEADBEEF at 0x8000_0010, then READ word at the same address -> READY_WRITE in cycle N+1; READY_READ with rdata 0xDEADBEEF two cycles after the read is presented.
REQ-030 Byte and halfword lanes: WRITE byte 0xAA at 0x8000_0013, then READ word at 0x8000_0010 -> 0xAAADBEEF; READ halfword at 0x8000_0012 -> 0x0000AAAD.
REQ-031 Illegal requests, each -> READY_ILLEGAL, rdata 0, memory unchanged:
- READ word at 0x8000_0011;
- READ at BASE+4*DEPTH (0x8000_1000);
- AMO_READ byte.
REQ-032 WAIT_CYCLES=3: READ presented in cycle 10 -> NOT_READY in cycles 10-13, ready in cycle 14 only, NOT_READY in cycle 15 with the next request held.
REQ-033 WAIT_CYCLES=3: WRITE, then cmd driven to NOP in the second WAIT cycle -> no ready pulse; a subsequent READ returns the old data.
REQ-034 i_rst_n pulsed low during WAIT of a WRITE -> status NOT_READY immediately, memory unchanged, and the next READ completes with normal latency.
